// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants used by the register file and its decoder.
package cpu_pkg;

   localparam int         REG_ADDR_W = 4;
   localparam int         NUM_REGS   = 16;
   localparam logic [3:0] REG_PC     = 4'd15;
   localparam logic [3:0] REG_LR     = 4'd14;

endpackage

// File: rtl/decoder_4_16.sv
// One-hot write-enable decoder: drives y[a] high when en is set, all zero otherwise.
module decoder_4_16
   import cpu_pkg::*;
(
   input  logic                  en,
   input  logic [REG_ADDR_W-1:0] a,
   output logic [NUM_REGS-1:0]   y
);

   always_comb begin
      y = '0;
      if (en) y[a] = 1'b1;
   end

endmodule

// File: rtl/reg_file_16.sv
// ARM register file: R0-R14 in flops, R15 reads return PC+8, R14 has a dedicated
// link-write port for BL. Three combinational read ports with no write bypass.
module reg_file_16
   import cpu_pkg::*;
#(
   parameter int W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [REG_ADDR_W-1:0] wa,
   input  logic [W-1:0]          wd,
   input  logic                  lr_we,
   input  logic [W-1:0]          lr_wd,
   input  logic [REG_ADDR_W-1:0] ra1,
   input  logic [REG_ADDR_W-1:0] ra2,
   input  logic [REG_ADDR_W-1:0] ra3,
   input  logic [W-1:0]          r15_in,
   output logic [W-1:0]          rd1,
   output logic [W-1:0]          rd2,
   output logic [W-1:0]          rd3
);

   logic [NUM_REGS-1:0] en;
   logic [W-1:0]        regs     [0:NUM_REGS-2];
   logic [W-1:0]        read_arr [0:NUM_REGS-1];
   logic                unused_pc_en;

   decoder_4_16 u_wdec (
      .en (we),
      .a  (wa),
      .y  (en)
   );

   // R15 has no storage, so its enable is simply dropped.
   assign unused_pc_en = en[REG_PC];

   for (genvar i = 0; i < NUM_REGS - 2; i++) begin : g_gpr
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)     regs[i] <= '0;
         else if (en[i]) regs[i] <= wd;
      end
   end

   // The link write takes priority over a main write aimed at R14.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              regs[REG_LR] <= '0;
      else if (lr_we)          regs[REG_LR] <= lr_wd;
      else if (en[REG_LR])     regs[REG_LR] <= wd;
   end

   always_comb begin
      for (int i = 0; i < NUM_REGS - 1; i++) read_arr[i] = regs[i];
      read_arr[REG_PC] = r15_in;
   end

   assign rd1 = read_arr[ra1];
   assign rd2 = read_arr[ra2];
   assign rd3 = read_arr[ra3];

endmodule

// File: tb/tb_reg_file_16.sv
// Bench for reg_file_16: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an array model of R0-R14.
module tb_reg_file_16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we;
   logic [3:0]  wa;
   logic [31:0] wd;
   logic        lr_we;
   logic [31:0] lr_wd;
   logic [3:0]  ra1, ra2, ra3;
   logic [31:0] r15_in;
   logic [31:0] rd1, rd2, rd3;

   int          n_vec = 0;
   int          n_err = 0;
   bit          cmp_en = 1'b0;
   logic [31:0] model [0:14];

   reg_file_16 #(.W(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (we),
      .wa     (wa),
      .wd     (wd),
      .lr_we  (lr_we),
      .lr_wd  (lr_wd),
      .ra1    (ra1),
      .ra2    (ra2),
      .ra3    (ra3),
      .r15_in (r15_in),
      .rd1    (rd1),
      .rd2    (rd2),
      .rd3    (rd3)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 15; i++) model[i] = 32'h0;
      end else begin
         if (we && wa != 4'd15) model[wa] = wd;
         if (lr_we) model[14] = lr_wd;
      end
   end

   function automatic logic [31:0] exp_rd(input logic [3:0] ra);
      return (ra == 4'd15) ? r15_in : model[ra];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      #2;
      if (cmp_en) begin
         check("rand_rd1", rd1, exp_rd(ra1));
         check("rand_rd2", rd2, exp_rd(ra2));
         check("rand_rd3", rd3, exp_rd(ra3));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      we = 1'b0; wa = 4'd0; wd = 32'h0;
      lr_we = 1'b0; lr_wd = 32'h0;
   endtask

   task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      we = 1'b1; wa = a; wd = d;
      @(posedge clk); #1;
      we = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      idle_inputs();
      ra1 = 4'd3; ra2 = 4'd15; ra3 = 4'd0; r15_in = 32'h0000_0108;
      #3;
      check("reset_rd1", rd1, 32'h0);
      check("reset_r15", rd2, 32'h0000_0108);

      @(negedge clk) rst_n = 1'b1;

      // basic write, old value visible before the edge
      @(negedge clk);
      we = 1'b1; wa = 4'd5; wd = 32'hDEAD_BEEF; ra1 = 4'd5;
      #1 check("pre_edge_old", rd1, 32'h0);
      @(posedge clk); #1;
      check("basic_write", rd1, 32'hDEAD_BEEF);
      we = 1'b0;

      // R15 write is ignored
      write_reg(4'd15, 32'h1234_5678);
      ra1 = 4'd15; r15_in = 32'h0000_0200;
      #1 check("r15_read", rd1, 32'h0000_0200);
      for (int i = 0; i < 15; i++) begin
         ra1 = 4'(i);
         #1 check("r15_sweep", rd1, (i == 5) ? 32'hDEAD_BEEF : 32'h0);
      end

      // link collision: lr_wd wins on R14
      @(negedge clk);
      we = 1'b1; wa = 4'd14; wd = 32'hAAAA_0000; lr_we = 1'b1; lr_wd = 32'h0000_BBBB;
      @(posedge clk); #1;
      idle_inputs();
      ra1 = 4'd14; ra2 = 4'd2;
      #1 check("collide_r14", rd1, 32'h0000_BBBB);
      check("collide_r2", rd2, 32'h0);

      // parallel main + link writes
      @(negedge clk);
      we = 1'b1; wa = 4'd2; wd = 32'hAAAA_0000; lr_we = 1'b1; lr_wd = 32'h0000_CCCC;
      @(posedge clk); #1;
      idle_inputs();
      #1 check("parallel_r14", rd1, 32'h0000_CCCC);
      check("parallel_r2", rd2, 32'hAAAA_0000);

      // triple read
      write_reg(4'd1, 32'h11);
      write_reg(4'd2, 32'h22);
      ra1 = 4'd1; ra2 = 4'd2; ra3 = 4'd1;
      #1 check("triple_rd1", rd1, 32'h11);
      check("triple_rd2", rd2, 32'h22);
      check("triple_rd3", rd3, 32'h11);

      // fill R0-R14 with 1..15, then async reset between edges
      for (int i = 0; i < 15; i++) write_reg(4'(i), 32'(i + 1));
      for (int i = 0; i < 15; i++) begin
         ra1 = 4'(i);
         #1 check("fill", rd1, 32'(i + 1));
      end
      ra1 = 4'd0; ra2 = 4'd9; ra3 = 4'd14;
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("async_rd1", rd1, 32'h0);
      check("async_rd2", rd2, 32'h0);
      check("async_rd3", rd3, 32'h0);

      // write while reset is held across an edge
      @(negedge clk);
      we = 1'b1; wa = 4'd7; wd = 32'hFFFF_FFFF; ra1 = 4'd7;
      @(posedge clk); #1;
      check("write_in_reset", rd1, 32'h0);
      we = 1'b0; rst_n = 1'b1;
      #1 check("after_reset", rd1, 32'h0);

      // randomized traffic
      idle_inputs();
      @(negedge clk);
      cmp_en = 1'b1;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         we     = ($urandom_range(0, 3) != 0);
         wa     = 4'($urandom_range(0, 15));
         wd     = $urandom;
         lr_we  = ($urandom_range(0, 3) == 0);
         lr_wd  = $urandom;
         ra1    = 4'($urandom_range(0, 15));
         ra2    = ($urandom_range(0, 3) == 0) ? ra1 : 4'($urandom_range(0, 15));
         ra3    = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
         r15_in = $urandom;
         rst_n  = ($urandom_range(0, 59) != 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      cmp_en = 1'b0;
      #5;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
